// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the execute-stage ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use stall with bubble insertion, branch flush and downstream hold.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int OP_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_uses_rs1,
   input  logic              in_uses_rs2,
   input  logic [DATA_W-1:0] in_rdata1,
   input  logic [DATA_W-1:0] in_rdata2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic              in_is_load,
   input  logic              in_reg_write,
   input  logic              flush,
   input  logic              hold,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic              exmem_reg_write,
   input  logic              exmem_is_load,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic              memwb_reg_write,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              stall_out,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_is_load,
   output logic [OP_W-1:0]   ex_op,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_data1,
   output logic [DATA_W-1:0] ex_data2,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [15:0]       bubble_count
);

   logic              valid_q, valid_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic              uses1_q, uses1_d, uses2_q, uses2_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
   logic              use_imm_q, use_imm_d;
   logic              is_load_q, is_load_d, reg_write_q, reg_write_d;
   logic [15:0]       bubble_count_q, bubble_count_d;
   logic              load_use;
   logic [DATA_W-1:0] fwd1, fwd2;

   // Loads in EX/MEM are never forwarded; the load-use stall keeps consumers out of their way.
   function automatic logic [DATA_W-1:0] fwd(
      input logic [REG_W-1:0]  src,
      input logic              used,
      input logic [DATA_W-1:0] stored,
      input logic [REG_W-1:0]  xm_rd,
      input logic              xm_we,
      input logic              xm_ld,
      input logic [DATA_W-1:0] xm_res,
      input logic [REG_W-1:0]  mw_rd,
      input logic              mw_we,
      input logic [DATA_W-1:0] mw_res
   );
      logic [DATA_W-1:0] val;
      val = stored;
      if (src != '0 && used) begin
         if (xm_we && !xm_ld && xm_rd == src) begin
            val = xm_res;
         end else if (mw_we && mw_rd == src) begin
            val = mw_res;
         end
      end
      return val;
   endfunction

   always_comb begin
      load_use = valid_q && is_load_q && (rd_q != '0) && in_valid &&
                 ((in_uses_rs1 && in_rs1 == rd_q) || (in_uses_rs2 && in_rs2 == rd_q));
      stall_out = load_use && !flush && !hold;
   end

   always_comb begin
      valid_d        = valid_q;
      op_d           = op_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      rd_d           = rd_q;
      uses1_d        = uses1_q;
      uses2_d        = uses2_q;
      rdata1_d       = rdata1_q;
      rdata2_d       = rdata2_q;
      imm_d          = imm_q;
      use_imm_d      = use_imm_q;
      is_load_d      = is_load_q;
      reg_write_d    = reg_write_q;
      bubble_count_d = bubble_count_q;

      if (flush || (!hold && load_use)) begin
         // Bubble: an all-zero entry, identical to the reset state.
         valid_d     = 1'b0;
         op_d        = '0;
         rs1_d       = '0;
         rs2_d       = '0;
         rd_d        = '0;
         uses1_d     = 1'b0;
         uses2_d     = 1'b0;
         rdata1_d    = '0;
         rdata2_d    = '0;
         imm_d       = '0;
         use_imm_d   = 1'b0;
         is_load_d   = 1'b0;
         reg_write_d = 1'b0;
         if (!flush && bubble_count_q != 16'hFFFF) begin
            bubble_count_d = bubble_count_q + 16'd1;
         end
      end else if (!hold) begin
         valid_d     = in_valid;
         rs1_d       = in_rs1;
         rs2_d       = in_rs2;
         rdata1_d    = in_rdata1;
         rdata2_d    = in_rdata2;
         imm_d       = in_imm;
         use_imm_d   = in_use_imm;
         op_d        = in_valid ? in_op        : '0;
         rd_d        = in_valid ? in_rd        : '0;
         uses1_d     = in_valid && in_uses_rs1;
         uses2_d     = in_valid && in_uses_rs2;
         is_load_d   = in_valid && in_is_load;
         reg_write_d = in_valid && in_reg_write;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q        <= 1'b0;
         op_q           <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         rd_q           <= '0;
         uses1_q        <= 1'b0;
         uses2_q        <= 1'b0;
         rdata1_q       <= '0;
         rdata2_q       <= '0;
         imm_q          <= '0;
         use_imm_q      <= 1'b0;
         is_load_q      <= 1'b0;
         reg_write_q    <= 1'b0;
         bubble_count_q <= '0;
      end else begin
         valid_q        <= valid_d;
         op_q           <= op_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         rd_q           <= rd_d;
         uses1_q        <= uses1_d;
         uses2_q        <= uses2_d;
         rdata1_q       <= rdata1_d;
         rdata2_q       <= rdata2_d;
         imm_q          <= imm_d;
         use_imm_q      <= use_imm_d;
         is_load_q      <= is_load_d;
         reg_write_q    <= reg_write_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   always_comb begin
      fwd1 = fwd(rs1_q, uses1_q, rdata1_q, exmem_rd, exmem_reg_write, exmem_is_load,
                 exmem_result, memwb_rd, memwb_reg_write, memwb_result);
      fwd2 = fwd(rs2_q, uses2_q, rdata2_q, exmem_rd, exmem_reg_write, exmem_is_load,
                 exmem_result, memwb_rd, memwb_reg_write, memwb_result);
      ex_data1      = fwd1;
      ex_data2      = use_imm_q ? imm_q : fwd2;
      ex_store_data = fwd2;
      ex_valid      = valid_q;
      ex_op         = op_q;
      ex_rd         = rd_q;
      ex_is_load    = is_load_q;
      ex_reg_write  = reg_write_q;
      bubble_count  = bubble_count_q;
   end

endmodule
